// File: rtl/decode_ctrl_stage_if.sv
// ID/EX boundary bundle for decode_ctrl_stage: IF/ID handshake, EX controls and the
// registered control word.
interface decode_ctrl_stage_if;
   logic        IN_VALID;
   logic [31:0] INSTR;
   logic        IN_READY;
   logic        FLUSH;
   logic        EX_STALL;
   logic        OUT_VALID;
   logic        WRITE_ENABLE;
   logic        MEM_WRITE;
   logic        MEM_READ;
   logic        BRANCH;
   logic        JUMP;
   logic        PC_SELECT;
   logic        JAL_SELECT;
   logic        DATA_MEM_SELECT;
   logic [2:0]  IMM_PICK;
   logic [2:0]  ALU_OP;
   logic [2:0]  FUNC3_OUT;
   logic [4:0]  RD_OUT;
   logic        ILLEGAL;

   modport master (
      output IN_VALID, INSTR, FLUSH, EX_STALL,
      input  IN_READY, OUT_VALID, WRITE_ENABLE, MEM_WRITE, MEM_READ, BRANCH, JUMP,
             PC_SELECT, JAL_SELECT, DATA_MEM_SELECT, IMM_PICK, ALU_OP, FUNC3_OUT,
             RD_OUT, ILLEGAL
   );

   modport slave (
      input  IN_VALID, INSTR, FLUSH, EX_STALL,
      output IN_READY, OUT_VALID, WRITE_ENABLE, MEM_WRITE, MEM_READ, BRANCH, JUMP,
             PC_SELECT, JAL_SELECT, DATA_MEM_SELECT, IMM_PICK, ALU_OP, FUNC3_OUT,
             RD_OUT, ILLEGAL
   );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) control decoder registered into the ID/EX boundary, with valid/ready flow
// control, EX back-pressure, branch flush and load-use bubble insertion.
module decode_ctrl_stage #(
   parameter int unsigned ENABLE_M       = 1,
   parameter int unsigned LOAD_USE_STALL = 1,
   parameter int unsigned STRICT_DECODE  = 1
) (
   input logic            CLK,
   input logic            RESET_N,
   decode_ctrl_stage_if.slave ctrl
);

   typedef struct packed {
      logic       ill;
      logic       we;
      logic       mw;
      logic       mr;
      logic       br;
      logic       jump;
      logic       pcsel;
      logic       jalsel;
      logic       dms;
      logic [2:0] imm;
      logic [2:0] alu;
      logic [2:0] f3;
      logic [4:0] rd;
   } cw_t;

   typedef enum logic {RUN, STALL} state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALL - 1);

   state_t     state_q;
   logic [1:0] cnt_q;
   logic       valid_q;
   cw_t        cw_q;
   cw_t        cw_d;
   logic       hazard;
   logic       in_ready;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rs1;
   logic [4:0] rs2;

   assign opc = ctrl.INSTR[6:0];
   assign f3  = ctrl.INSTR[14:12];
   assign f7  = ctrl.INSTR[31:25];
   assign rs1 = ctrl.INSTR[19:15];
   assign rs2 = ctrl.INSTR[24:20];

   always_comb begin
      logic ill;
      ill  = 1'b0;
      cw_d = '0;
      unique case (opc)
         OPC_OP: begin
            if (f7 == 7'b0000001) begin
               if (ENABLE_M != 0) begin
                  cw_d.we  = 1'b1;
                  cw_d.alu = 3'b110;
               end else begin
                  ill = 1'b1;
               end
            end else if (f7 == 7'b0000000 || f7 == 7'b0100000 || STRICT_DECODE == 0) begin
               cw_d.we  = 1'b1;
               cw_d.alu = 3'b000;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_LOAD: begin
            if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) begin
               cw_d.we  = 1'b1;
               cw_d.mr  = 1'b1;
               cw_d.dms = 1'b1;
               cw_d.alu = 3'b001;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_JALR: begin
            if (f3 == 3'd0) begin
               cw_d.we     = 1'b1;
               cw_d.jalsel = 1'b1;
               cw_d.jump   = 1'b1;
               cw_d.alu    = 3'b010;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_OPIMM: begin
            // Shift-immediates carry funct7 in the immediate field and must be checked.
            if ((f3 != 3'd1 && f3 != 3'd5) ||
                (f3 == 3'd1 && f7 == 7'b0000000) ||
                (f3 == 3'd5 && (f7 == 7'b0000000 || f7 == 7'b0100000))) begin
               cw_d.we  = 1'b1;
               cw_d.alu = 3'b011;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_STORE: begin
            if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) begin
               cw_d.mw  = 1'b1;
               cw_d.imm = 3'b001;
               cw_d.alu = 3'b100;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_LUI: begin
            cw_d.we  = 1'b1;
            cw_d.imm = 3'b010;
            cw_d.alu = 3'b101;
         end
         OPC_AUIPC: begin
            cw_d.we    = 1'b1;
            cw_d.imm   = 3'b010;
            cw_d.pcsel = 1'b1;
            cw_d.alu   = 3'b100;
         end
         OPC_BRANCH: begin
            if (f3 != 3'd2 && f3 != 3'd3) begin
               cw_d.br    = 1'b1;
               cw_d.pcsel = 1'b1;
               cw_d.imm   = 3'b011;
               cw_d.alu   = 3'b100;
            end else begin
               ill = 1'b1;
            end
         end
         OPC_JAL: begin
            cw_d.jump   = 1'b1;
            cw_d.jalsel = 1'b1;
            cw_d.pcsel  = 1'b1;
            cw_d.imm    = 3'b100;
            cw_d.we     = 1'b1;
            cw_d.alu    = 3'b100;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         cw_d     = '0;
         cw_d.ill = 1'b1;
      end
      cw_d.f3 = f3;
      cw_d.rd = ctrl.INSTR[11:7];
   end

   always_comb begin
      logic uses_rs1;
      logic uses_rs2;
      uses_rs1 = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
      uses_rs2 = (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
      hazard   = valid_q && cw_q.mr && (cw_q.rd != 5'd0) && ctrl.IN_VALID &&
                 ((uses_rs1 && rs1 == cw_q.rd) || (uses_rs2 && rs2 == cw_q.rd));
   end

   always_comb begin
      in_ready = 1'b0;
      if (!RESET_N)           in_ready = 1'b0;
      else if (ctrl.FLUSH)    in_ready = 1'b1;
      else if (ctrl.EX_STALL) in_ready = 1'b0;
      else if (state_q == RUN) in_ready = !hazard;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         valid_q <= 1'b0;
         cw_q    <= '0;
         state_q <= RUN;
         cnt_q   <= '0;
      end else if (ctrl.FLUSH) begin
         valid_q <= 1'b0;
         cw_q    <= '0;
         state_q <= RUN;
         cnt_q   <= '0;
      end else if (!ctrl.EX_STALL) begin
         unique case (state_q)
            RUN: begin
               if (hazard) begin
                  valid_q <= 1'b0;
                  cw_q    <= '0;
                  if (LOAD_USE_STALL > 1) begin
                     state_q <= STALL;
                     cnt_q   <= CNT_INIT;
                  end
               end else if (ctrl.IN_VALID) begin
                  valid_q <= 1'b1;
                  cw_q    <= cw_d;
               end else begin
                  valid_q <= 1'b0;
                  cw_q    <= '0;
               end
            end
            STALL: begin
               valid_q <= 1'b0;
               cw_q    <= '0;
               cnt_q   <= cnt_q - 2'd1;
               if (cnt_q == 2'd1) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign ctrl.IN_READY        = in_ready;
   assign ctrl.OUT_VALID       = valid_q;
   assign ctrl.WRITE_ENABLE    = cw_q.we;
   assign ctrl.MEM_WRITE       = cw_q.mw;
   assign ctrl.MEM_READ        = cw_q.mr;
   assign ctrl.BRANCH          = cw_q.br;
   assign ctrl.JUMP            = cw_q.jump;
   assign ctrl.PC_SELECT       = cw_q.pcsel;
   assign ctrl.JAL_SELECT      = cw_q.jalsel;
   assign ctrl.DATA_MEM_SELECT = cw_q.dms;
   assign ctrl.IMM_PICK        = cw_q.imm;
   assign ctrl.ALU_OP          = cw_q.alu;
   assign ctrl.FUNC3_OUT       = cw_q.f3;
   assign ctrl.RD_OUT          = cw_q.rd;
   assign ctrl.ILLEGAL         = cw_q.ill;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench: three decode_ctrl_stage variants (M on/strict, M off/strict,
// M on/lenient) share one stimulus stream; a negedge monitor checks every output word.
module tb_decode_ctrl_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] instr;
   logic        flush;
   logic        ex_stall;
   logic        mon_en;

   int unsigned n_checks;
   int unsigned n_fail;

   typedef struct packed {
      logic [22:0] a;
      logic [22:0] b;
      logic [22:0] c;
   } exp_t;

   exp_t exp_q[$];

   decode_ctrl_stage_if ia ();
   decode_ctrl_stage_if ib ();
   decode_ctrl_stage_if ic ();

   assign ia.IN_VALID = in_valid;
   assign ia.INSTR    = instr;
   assign ia.FLUSH    = flush;
   assign ia.EX_STALL = ex_stall;
   assign ib.IN_VALID = in_valid;
   assign ib.INSTR    = instr;
   assign ib.FLUSH    = flush;
   assign ib.EX_STALL = ex_stall;
   assign ic.IN_VALID = in_valid;
   assign ic.INSTR    = instr;
   assign ic.FLUSH    = flush;
   assign ic.EX_STALL = ex_stall;

   decode_ctrl_stage #(.ENABLE_M(1), .LOAD_USE_STALL(2), .STRICT_DECODE(1)) u_a (
      .CLK(clk), .RESET_N(rst_n), .ctrl(ia.slave));
   decode_ctrl_stage #(.ENABLE_M(0), .LOAD_USE_STALL(2), .STRICT_DECODE(1)) u_b (
      .CLK(clk), .RESET_N(rst_n), .ctrl(ib.slave));
   decode_ctrl_stage #(.ENABLE_M(1), .LOAD_USE_STALL(2), .STRICT_DECODE(0)) u_c (
      .CLK(clk), .RESET_N(rst_n), .ctrl(ic.slave));

   logic [22:0] wa, wb, wc;
   assign wa = {ia.ILLEGAL, ia.WRITE_ENABLE, ia.MEM_WRITE, ia.MEM_READ, ia.BRANCH, ia.JUMP,
                ia.PC_SELECT, ia.JAL_SELECT, ia.DATA_MEM_SELECT, ia.IMM_PICK, ia.ALU_OP,
                ia.FUNC3_OUT, ia.RD_OUT};
   assign wb = {ib.ILLEGAL, ib.WRITE_ENABLE, ib.MEM_WRITE, ib.MEM_READ, ib.BRANCH, ib.JUMP,
                ib.PC_SELECT, ib.JAL_SELECT, ib.DATA_MEM_SELECT, ib.IMM_PICK, ib.ALU_OP,
                ib.FUNC3_OUT, ib.RD_OUT};
   assign wc = {ic.ILLEGAL, ic.WRITE_ENABLE, ic.MEM_WRITE, ic.MEM_READ, ic.BRANCH, ic.JUMP,
                ic.PC_SELECT, ic.JAL_SELECT, ic.DATA_MEM_SELECT, ic.IMM_PICK, ic.ALU_OP,
                ic.FUNC3_OUT, ic.RD_OUT};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Word layout: {ill, we, mw, mr, br, jump, pcsel, jalsel, dms, imm, alu, f3, rd}
   function automatic logic [22:0] cw(input logic ill, we, mw, mr, br, jmp, pcs, jals, dms,
                                      input logic [2:0] imm, alu, f3, input logic [4:0] rd);
      return {ill, we, mw, mr, br, jmp, pcs, jals, dms, imm, alu, f3, rd};
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid_b_vs_a", 32'(ib.OUT_VALID), 32'(ia.OUT_VALID));
         chk("valid_c_vs_a", 32'(ic.OUT_VALID), 32'(ia.OUT_VALID));
         if (ia.OUT_VALID) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'(wa), 32'h0);
               chk("unexpected_output_q", 32'd0, 32'd1);
            end else begin
               chk("word_a", 32'(wa), 32'(exp_q[0].a));
               chk("word_b", 32'(wb), 32'(exp_q[0].b));
               chk("word_c", 32'(wc), 32'(exp_q[0].c));
               if (!ex_stall || flush) void'(exp_q.pop_front());
            end
         end else begin
            chk("bubble_a", 32'(wa), 32'h0);
            chk("bubble_b", 32'(wb), 32'h0);
            chk("bubble_c", 32'(wc), 32'h0);
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [22:0] ea, eb, ec,
                       output int waits);
      exp_t e;
      in_valid = 1'b1;
      instr    = ins;
      waits    = 0;
      forever begin
         @(negedge clk);
         if (ia.IN_READY) break;
         waits++;
         if (waits > 20) begin
            chk("accept_timeout", 32'(waits), 32'd0);
            break;
         end
      end
      e.a = ea;
      e.b = eb;
      e.c = ec;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW5   = 32'h0000A283;
   localparam logic [31:0] I_ADD6  = 32'h00228333;
   localparam logic [31:0] I_LW0   = 32'h0000A003;
   localparam logic [31:0] I_ADD60 = 32'h00200333;
   localparam logic [31:0] I_LUI5  = 32'h123452B7;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_JAL   = 32'h010000EF;
   localparam logic [31:0] I_MUL   = 32'h022083B3;
   localparam logic [31:0] I_ZERO  = 32'h00000000;
   localparam logic [31:0] I_F7X   = 32'h042083B3;

   initial begin
      int w;
      logic [22:0] e_addi, e_lw5, e_add6, e_lw0, e_lui5, e_sw, e_beq, e_jal;
      logic [22:0] e_mul, e_mul_ill, e_zero, e_f7_ill, e_f7_ok;
      e_addi    = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b011, 3'd0, 5'd1);
      e_lw5     = cw(0, 1, 0, 1, 0, 0, 0, 0, 1, 3'b000, 3'b001, 3'd2, 5'd5);
      e_add6    = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'd0, 5'd6);
      e_lw0     = cw(0, 1, 0, 1, 0, 0, 0, 0, 1, 3'b000, 3'b001, 3'd2, 5'd0);
      e_lui5    = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b101, 3'd5, 5'd5);
      e_sw      = cw(0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b001, 3'b100, 3'd2, 5'd4);
      e_beq     = cw(0, 0, 0, 0, 1, 0, 1, 0, 0, 3'b011, 3'b100, 3'd0, 5'd8);
      e_jal     = cw(0, 1, 0, 0, 0, 1, 1, 1, 0, 3'b100, 3'b100, 3'd0, 5'd1);
      e_mul     = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b110, 3'd0, 5'd7);
      e_mul_ill = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'd0, 5'd7);
      e_zero    = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'd0, 5'd0);
      e_f7_ill  = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'd0, 5'd7);
      e_f7_ok   = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'd0, 5'd7);

      n_checks = 0;
      n_fail   = 0;
      mon_en   = 1'b0;
      rst_n    = 1'b0;
      in_valid = 1'b1;
      instr    = I_ADDI;
      flush    = 1'b0;
      ex_stall = 1'b0;

      // Reset held with a valid instruction offered
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("reset_in_ready", 32'(ia.IN_READY), 32'd0);
         chk("reset_out_valid", 32'(ia.OUT_VALID), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(I_ADDI, e_addi, e_addi, e_addi, w);
      chk("addi_wait", 32'(w), 32'd0);

      // Load-use hazard: two bubbles before the dependent ADD
      send(I_LW5, e_lw5, e_lw5, e_lw5, w);
      chk("lw5_wait", 32'(w), 32'd0);
      send(I_ADD6, e_add6, e_add6, e_add6, w);
      chk("loaduse_bubbles", 32'(w), 32'd2);

      // rd=x0 load and non-rs consumer never stall
      send(I_LW0, e_lw0, e_lw0, e_lw0, w);
      send(I_ADD60, e_add6, e_add6, e_add6, w);
      chk("x0_load_no_stall", 32'(w), 32'd0);
      send(I_LW5, e_lw5, e_lw5, e_lw5, w);
      send(I_LUI5, e_lui5, e_lui5, e_lui5, w);
      chk("lui_no_stall", 32'(w), 32'd0);

      // EX back-pressure then flush while still stalled
      send(I_SW, e_sw, e_sw, e_sw, w);
      ex_stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("exstall_in_ready", 32'(ia.IN_READY), 32'd0);
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(ia.IN_READY), 32'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      ex_stall = 1'b0;
      @(negedge clk);
      chk("flush_bubble_valid", 32'(ia.OUT_VALID), 32'd0);
      @(posedge clk);
      #1;

      send(I_BEQ, e_beq, e_beq, e_beq, w);
      send(I_JAL, e_jal, e_jal, e_jal, w);
      chk("jal_back_to_back", 32'(w), 32'd0);

      // Parameter-dependent decode
      send(I_MUL, e_mul, e_mul_ill, e_mul, w);
      send(I_ZERO, e_zero, e_zero, e_zero, w);
      send(I_F7X, e_f7_ill, e_f7_ill, e_f7_ok, w);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
